regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//  Shares the single 8x16 register-file port set (rA/rB read, rD write) between two requesters:
//  client 0 (decode/operand fetch) and client 1 (writeback/debug). Round-robin arbitration,
//  optional multi-cycle lock for atomic sequences, and routing of the 1-cycle-latency read data
//  back to the owning client. Sits between the control path and the register file instance.
// PARAMETERS
//  DATA_W  16  register data width
//  SEL_W   3   register select width (2**SEL_W registers)
// PORTS
//  clk          in   1         system clock, all state on posedge
//  rst_n        in   1         synchronous reset, active-low
//  req          in   2         per-client access request; bit i = client i
//  lock         in   2         hold ownership after this grant
//  ra_sel       in   2*SEL_W   read-A select; client i in bits [i*SEL_W +: SEL_W]
//  rb_sel       in   2*SEL_W   read-B select, packed as ra_sel
//  rd_sel       in   2*SEL_W   write select, packed as ra_sel
//  rd_data      in   2*DATA_W  write data; client i in bits [i*DATA_W +: DATA_W]
//  rd_write     in   2         write enable per client, used only when granted
//  gnt          out  2         one-hot-or-zero grant, combinational, same cycle as req
//  rsp_valid    out  2         registered: rsp_a/rsp_b valid for client i this cycle
//  rsp_a        out  DATA_W    read-A data for the client flagged by rsp_valid
//  rsp_b        out  DATA_W    read-B data for the client flagged by rsp_valid
//  rf_enable    out  1         register-file enable
//  rf_ra_sel    out  SEL_W     register-file rA_select
//  rf_rb_sel    out  SEL_W     register-file rB_select
//  rf_rd_sel    out  SEL_W     register-file rD_select
//  rf_rd_in     out  DATA_W    register-file rD_in
//  rf_rd_write  out  1         register-file rD_write
//  rf_ra_out    in   DATA_W    register-file rA_out (registered inside the file)
//  rf_rb_out    in   DATA_W    register-file rB_out
// BEHAVIOUR
//  - States: IDLE, OWN0, OWN1. Round-robin pointer rr (1 bit) = preferred client on a tie.
//  - IDLE: one req -> grant it; both req -> grant client rr. No req -> gnt=0.
//  - OWNi: only client i can be granted; the other client's req is ignored (no grant, no drop).
//  - Transitions on the grant cycle of client i: lock[i]=1 -> OWNi; lock[i]=0 -> IDLE.
//    In OWNi with req[i]=0 -> IDLE, no grant that cycle.
//  - rr <= ~i whenever client i is granted and next state is IDLE; unchanged while locked.
//  - rf_enable = |gnt. rf_*_sel/rf_rd_in muxed from the granted client; rf_rd_write = gnt[i]&rd_write[i].
//    No grant: all rf_* selects/data = 0, rf_rd_write = 0.
//  - Latency: grant in cycle N -> rsp_valid[i]=1 in cycle N+1 only (1-cycle pulse per grant).
//    Every grant produces a response, including write-only accesses.
//  - rsp_a/rsp_b = rf_ra_out/rf_rb_out (or bypass value below); meaningful only with rsp_valid.
//  - Same-access read/write of the same register: the file returns the pre-write value.
//    The next access sees the new value.
//  - Back-to-back grants (either client) every cycle are allowed; no bubble.
//  - Reset (rst_n=0 at posedge): state=IDLE, rr=0, rsp_valid=0, bypass regs=0.
//    gnt=0, rf_enable=0, rf_rd_write=0 while rst_n=0.
//    Reset mid-lock releases ownership; a pending response is dropped. Register contents are not reset.
// CONFIGURATION
//  REGFILE_ARB_BYPASS_EN defined: at grant, hit_a = rd_write & (rd_sel==ra_sel), same for B,
//    registered with rd_data. In N+1, rsp_a = hit_a ? captured rd_data : rf_ra_out (same for B).
//    The result is write-before-read semantics within one access.
//  REGFILE_ARB_BYPASS_EN undefined: no bypass logic; read-before-write as above.
// TESTING
//  1 c0 writes r1=0x1111, then r2=0x2222; then c0 req ra=1 rb=2 -> gnt=01 same cycle;
//    next cycle rsp_valid=01, rsp_a=0x1111, rsp_b=0x2222.
//  2 after reset both req held, lock=0 -> gnt sequence 01,10,01,10; rsp_valid follows 1 cycle later.
//  3 c1 granted with lock=1 for 3 grants, then lock=0, c0 req throughout -> gnt=10 x4, then 01.
//  4 r3=0x0001; single access rd_write=1 rd_sel=3 rd_data=0xBEEF ra_sel=3 -> rsp_a=0xBEEF with
//    REGFILE_ARB_BYPASS_EN, 0x0001 without; following read of r3 -> 0xBEEF in both builds.
//  5 rst_n=0 for 1 cycle while in OWN1 with rsp pending -> rsp_valid=00 after reset;
//    then both req -> gnt=01.
//  6 req=00 for 10 cycles -> rf_enable=0, rf_rd_write=0, rsp_valid=00; rf_ra_out unchanged.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register-file port set (rA/rB read, rD write) between two clients.
// Optional write-before-read bypass enabled by defining REGFILE_ARB_BYPASS_EN.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic [2*SEL_W-1:0]    ra_sel,
    input  logic [2*SEL_W-1:0]    rb_sel,
    input  logic [2*SEL_W-1:0]    rd_sel,
    input  logic [2*DATA_W-1:0]   rd_data,
    input  logic [1:0]            rd_write,
    output logic [1:0]            gnt,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_a,
    output logic [DATA_W-1:0]     rsp_b,
    output logic                  rf_enable,
    output logic [SEL_W-1:0]      rf_ra_sel,
    output logic [SEL_W-1:0]      rf_rb_sel,
    output logic [SEL_W-1:0]      rf_rd_sel,
    output logic [DATA_W-1:0]     rf_rd_in,
    output logic                  rf_rd_write,
    input  logic [DATA_W-1:0]     rf_ra_out,
    input  logic [DATA_W-1:0]     rf_rb_out
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state_reg;
    logic            rr_reg;
    logic [1:0]      rsp_valid_reg;
    logic [1:0]      gnt_next;
    logic            grant_any;
    logic            gnt_idx;

    logic [SEL_W-1:0]  ra_sel_c  [2];
    logic [SEL_W-1:0]  rb_sel_c  [2];
    logic [SEL_W-1:0]  rd_sel_c  [2];
    logic [DATA_W-1:0] rd_data_c [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign ra_sel_c[gi]  = ra_sel[gi*SEL_W +: SEL_W];
            assign rb_sel_c[gi]  = rb_sel[gi*SEL_W +: SEL_W];
            assign rd_sel_c[gi]  = rd_sel[gi*SEL_W +: SEL_W];
            assign rd_data_c[gi] = rd_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // While locked, the other client's request is simply not seen.
    always_comb begin
        gnt_next = 2'b00;
        if (rst_n) begin
            case (state_reg)
                IDLE:    gnt_next = (req == 2'b11) ? (rr_reg ? 2'b10 : 2'b01) : req;
                OWN0:    gnt_next = {1'b0, req[0]};
                OWN1:    gnt_next = {req[1], 1'b0};
                default: gnt_next = 2'b00;
            endcase
        end
    end

    assign grant_any = |gnt_next;
    assign gnt_idx   = gnt_next[1];
    assign gnt       = gnt_next;
    assign rf_enable = grant_any;
    assign rsp_valid = rsp_valid_reg;

    always_comb begin
        rf_ra_sel   = '0;
        rf_rb_sel   = '0;
        rf_rd_sel   = '0;
        rf_rd_in    = '0;
        rf_rd_write = 1'b0;
        if (grant_any) begin
            rf_ra_sel   = ra_sel_c[gnt_idx];
            rf_rb_sel   = rb_sel_c[gnt_idx];
            rf_rd_sel   = rd_sel_c[gnt_idx];
            rf_rd_in    = rd_data_c[gnt_idx];
            rf_rd_write = rd_write[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_reg        <= 1'b0;
            rsp_valid_reg <= 2'b00;
        end else begin
            rsp_valid_reg <= gnt_next;
            if (grant_any) begin
                if (lock[gnt_idx]) begin
                    state_reg <= gnt_idx ? OWN1 : OWN0;
                end else begin
                    state_reg <= IDLE;
                    rr_reg    <= ~gnt_idx;
                end
            end else begin
                // Owner dropped its request, or nobody asked.
                state_reg <= IDLE;
            end
        end
    end

`ifdef REGFILE_ARB_BYPASS_EN
    logic              hit_a_reg;
    logic              hit_b_reg;
    logic [DATA_W-1:0] byp_data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_a_reg    <= 1'b0;
            hit_b_reg    <= 1'b0;
            byp_data_reg <= '0;
        end else if (grant_any) begin
            hit_a_reg    <= rf_rd_write && (rf_rd_sel == rf_ra_sel);
            hit_b_reg    <= rf_rd_write && (rf_rd_sel == rf_rb_sel);
            byp_data_reg <= rf_rd_in;
        end else begin
            hit_a_reg <= 1'b0;
            hit_b_reg <= 1'b0;
        end
    end

    assign rsp_a = hit_a_reg ? byp_data_reg : rf_ra_out;
    assign rsp_b = hit_b_reg ? byp_data_reg : rf_rb_out;
`else
    assign rsp_a = rf_ra_out;
    assign rsp_b = rf_rb_out;
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural 8x16 register file (registered read).
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, lock, rd_write;
    logic [5:0]  ra_sel, rb_sel, rd_sel;
    logic [31:0] rd_data;
    logic [1:0]  gnt, rsp_valid;
    logic [15:0] rsp_a, rsp_b;
    logic        rf_enable, rf_rd_write;
    logic [2:0]  rf_ra_sel, rf_rb_sel, rf_rd_sel;
    logic [15:0] rf_rd_in, rf_ra_out, rf_rb_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        c;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;
    exp_t exp_q[$];

    logic [1:0]  last_gnt = 2'b00;
    logic        model_clr;
    logic [15:0] mem [8];

`ifdef REGFILE_ARB_BYPASS_EN
    localparam logic [15:0] EXP4 = 16'hBEEF;
`else
    localparam logic [15:0] EXP4 = 16'h0001;
`endif

    always #5 clk = ~clk;

    regfile_arbiter #(.DATA_W(16), .SEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .rd_sel(rd_sel), .rd_data(rd_data), .rd_write(rd_write),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rf_enable(rf_enable), .rf_ra_sel(rf_ra_sel), .rf_rb_sel(rf_rb_sel), .rf_rd_sel(rf_rd_sel),
        .rf_rd_in(rf_rd_in), .rf_rd_write(rf_rd_write), .rf_ra_out(rf_ra_out), .rf_rb_out(rf_rb_out)
    );

    // Register file: read returns the pre-write contents of the same access.
    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
        end else if (rf_enable) begin
            rf_ra_out <= mem[rf_ra_sel];
            rf_rb_out <= mem[rf_rb_sel];
            if (rf_rd_write) mem[rf_rd_sel] <= rf_rd_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_c(input int c, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input logic [15:0] d, input logic w);
        ra_sel[c*3 +: 3]   = ra;
        rb_sel[c*3 +: 3]   = rb;
        rd_sel[c*3 +: 3]   = rd;
        rd_data[c*16 +: 16] = d;
        rd_write[c]        = w;
    endtask

    // Inputs are already set at the current negedge; check grant side and queue the response.
    task automatic step(input logic [1:0] exp_gnt, input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        #1;
        chk("gnt", {30'd0, gnt}, {30'd0, exp_gnt});
        chk("rf_enable", {31'd0, rf_enable}, {31'd0, |exp_gnt});
        chk("rf_rd_write", {31'd0, rf_rd_write},
            {31'd0, (exp_gnt != 2'b00) ? rd_write[exp_gnt[1]] : 1'b0});
        chk("rsp_valid_lat", {30'd0, rsp_valid}, {30'd0, last_gnt});
        last_gnt = exp_gnt;
        if (exp_gnt != 2'b00) begin
            e.c = exp_gnt[1];
            e.a = ea;
            e.b = eb;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Every queued response is due exactly at the next negedge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.c ? 2'b10 : 2'b01});
            chk("rsp_a", {16'd0, rsp_a}, {16'd0, e.a});
            chk("rsp_b", {16'd0, rsp_b}, {16'd0, e.b});
            $display("rsp c%0d rsp_valid=%b a=%h b=%h", e.c, rsp_valid, rsp_a, rsp_b);
        end else if (rsp_valid !== 2'b00) begin
            chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
        end
    end

    initial begin
        rst_n = 1'b0; model_clr = 1'b1;
        req = 0; lock = 0; ra_sel = 0; rb_sel = 0; rd_sel = 0; rd_data = 0; rd_write = 0;
        repeat (2) @(negedge clk);
        req = 2'b11; rd_write = 2'b11;
        step(2'b00, 0, 0);
        model_clr = 1'b0; rst_n = 1'b1; req = 2'b00; rd_write = 2'b00;
        step(2'b00, 0, 0);

        // 1: writes then read back
        req = 2'b01;
        set_c(0, 3'd0, 3'd0, 3'd1, 16'h1111, 1'b1); step(2'b01, 16'h0000, 16'h0000);
        set_c(0, 3'd1, 3'd0, 3'd2, 16'h2222, 1'b1); step(2'b01, 16'h1111, 16'h0000);
        set_c(0, 3'd1, 3'd2, 3'd0, 16'h0000, 1'b0); step(2'b01, 16'h1111, 16'h2222);
        req = 2'b00; step(2'b00, 0, 0);

        // 2: alternate after reset
        rst_n = 1'b0; step(2'b00, 0, 0); rst_n = 1'b1;
        set_c(0, 3'd1, 3'd2, 3'd0, 16'h0000, 1'b0);
        set_c(1, 3'd2, 3'd1, 3'd0, 16'h0000, 1'b0);
        req = 2'b11;
        step(2'b01, 16'h1111, 16'h2222); step(2'b10, 16'h2222, 16'h1111);
        step(2'b01, 16'h1111, 16'h2222); step(2'b10, 16'h2222, 16'h1111);

        // 3: client 1 holds lock, client 0 waits
        set_c(1, 3'd1, 3'd2, 3'd0, 16'h0000, 1'b0);
        set_c(0, 3'd2, 3'd1, 3'd0, 16'h0000, 1'b0);
        req = 2'b10; lock = 2'b10; step(2'b10, 16'h1111, 16'h2222);
        req = 2'b11; step(2'b10, 16'h1111, 16'h2222); step(2'b10, 16'h1111, 16'h2222);
        lock = 2'b00; step(2'b10, 16'h1111, 16'h2222);
        step(2'b01, 16'h2222, 16'h1111);
        // OWN0: client 1 ignored, owner drop releases with no grant
        req = 2'b01; lock = 2'b01; step(2'b01, 16'h2222, 16'h1111);
        req = 2'b10; lock = 2'b00; step(2'b00, 0, 0);
        step(2'b10, 16'h1111, 16'h2222);

        // 4: same-access read/write of r3
        req = 2'b01;
        set_c(0, 3'd0, 3'd0, 3'd3, 16'h0001, 1'b1); step(2'b01, 16'h0000, 16'h0000);
        set_c(0, 3'd3, 3'd1, 3'd3, 16'hBEEF, 1'b1); step(2'b01, EXP4, 16'h1111);
        set_c(0, 3'd3, 3'd3, 3'd0, 16'h0000, 1'b0); step(2'b01, 16'hBEEF, 16'hBEEF);

        // 5: reset while client 1 owns with a response in flight
        set_c(1, 3'd3, 3'd2, 3'd0, 16'h0000, 1'b0);
        req = 2'b10; lock = 2'b10; step(2'b10, 16'hBEEF, 16'h2222);
        rst_n = 1'b0; req = 2'b11; set_c(1, 3'd3, 3'd2, 3'd4, 16'hDEAD, 1'b1);
        step(2'b00, 0, 0);
        rst_n = 1'b1; req = 2'b00; lock = 2'b00; rd_write = 2'b00;
        step(2'b00, 0, 0);
        set_c(0, 3'd1, 3'd2, 3'd0, 16'h0000, 1'b0);
        req = 2'b11; step(2'b01, 16'h1111, 16'h2222);

        // 6: idle for 10 cycles
        req = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step(2'b00, 0, 0);
            chk("rf_ra_out_hold", {16'd0, rf_ra_out}, 32'h0000_1111);
        end
        // r4 must not have been written during reset
        req = 2'b01; set_c(0, 3'd4, 3'd3, 3'd0, 16'h0000, 1'b0);
        step(2'b01, 16'h0000, 16'hBEEF);
        req = 2'b00; step(2'b00, 0, 0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
